// File: rtl/bit_shift_pkg.sv
// Shared constants and types for the parallel-load, serial-in left-shift register.
package bit_shift_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/bit_shift_cell.sv
// One bit of the shift register: a flop choosing between parallel data,
// the neighbour bit below it, or its own value.
module bit_shift_cell
    import bit_shift_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_bit,
    input  logic shift_bit,
    input  logic load,
    input  logic shift,
    output logic q
);

    // Load outranks shift; with neither enable the flop keeps its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_BIT;
        end else if (load) begin
            q <= load_bit;
        end else if (shift) begin
            q <= shift_bit;
        end
    end

endmodule

// File: rtl/bit_shift_8l.sv
// Parallel-load, serial-in left-shift register built from WIDTH bit cells;
// out comes straight from the cell flops.
module bit_shift_8l
    import bit_shift_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             inLSB,
    input  logic             load,
    input  logic             shift,
    output logic [WIDTH-1:0] out
);

    // Each cell shifts in from the cell below; cell 0 takes the serial input.
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_cell
            if (i == 0) begin : g_lsb
                bit_shift_cell #(
                    .RESET_BIT (RESET_VALUE[i])
                ) u_cell (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .load_bit  (in[i]),
                    .shift_bit (inLSB),
                    .load      (load),
                    .shift     (shift),
                    .q         (out[i])
                );
            end else begin : g_upper
                bit_shift_cell #(
                    .RESET_BIT (RESET_VALUE[i])
                ) u_cell (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .load_bit  (in[i]),
                    .shift_bit (out[i-1]),
                    .load      (load),
                    .shift     (shift),
                    .q         (out[i])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_bit_shift_8l.sv
// Bench for bit_shift_8l: a negedge driver queues expected words, a monitor
// compares them one clock edge later against the register output.
module tb_bit_shift_8l;
    import bit_shift_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in;
    logic         inLSB;
    logic         load;
    logic         shift;
    logic [W-1:0] out;

    logic [W-1:0] exp_q[$];
    int           total;
    int           bad;
    int           model;

    bit_shift_8l #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .inLSB (inLSB),
        .load  (load),
        .shift (shift),
        .out   (out)
    );

    // Clock and reset defaults
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: out=0x%02h expected=0x%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: byte arithmetic on an integer, load first, then shift, else hold.
    task automatic model_step(input logic l, input logic s, input logic [W-1:0] d, input logic b);
        if (l)
            model = int'(d);
        else if (s)
            model = (model * 2 + int'(b)) % (1 << W);
    endtask

    // Drive one edge's inputs; push the model's expectation.
    task automatic drive(input logic l, input logic s, input logic [W-1:0] d, input logic b);
        @(negedge clk);
        load  = l;
        shift = s;
        in    = d;
        inLSB = b;
        model_step(l, s, d, b);
        exp_q.push_back(W'(model));
    endtask

    // Drive one edge with an explicitly stated expected value from the test plan.
    task automatic drive_exp(input logic l, input logic s, input logic [W-1:0] d, input logic b,
                             input logic [W-1:0] exp);
        @(negedge clk);
        load  = l;
        shift = s;
        in    = d;
        inLSB = b;
        model_step(l, s, d, b);
        exp_q.push_back(exp);
    endtask

    // Monitor: compares just after each capturing edge whenever an expectation is pending.
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            check("scoreboard", out, exp_q.pop_front());
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        model = 0;
        rst_n = 1'b1;
        load  = 1'b0;
        shift = 1'b0;
        in    = '0;
        inLSB = 1'b0;

        // Reset with load requested and clocks running
        #1;
        rst_n = 1'b0;
        load  = 1'b1;
        in    = 8'hFF;
        #1;
        check("reset_immediate", out, 8'h00);
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", out, 8'h00);
        end
        load  = 1'b0;
        rst_n = 1'b1;
        drive_exp(1'b0, 1'b0, 8'hFF, 1'b1, 8'h00);
        drive_exp(1'b0, 1'b0, 8'h00, 1'b1, 8'h00);

        // Load then hold with random data on the ignored inputs
        drive_exp(1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5);
        repeat (5) drive_exp(1'b0, 1'b0, W'($urandom), 1'($urandom), 8'hA5);

        // Single shifts
        drive_exp(1'b0, 1'b1, W'($urandom), 1'b1, 8'h4B);
        drive_exp(1'b0, 1'b1, W'($urandom), 1'b0, 8'h96);

        // Load wins over a simultaneous shift
        drive_exp(1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C);

        // MSB discarded, ones fill up from the bottom
        drive_exp(1'b1, 1'b0, 8'h80, 1'b0, 8'h80);
        for (int k = 0; k < W; k++)
            drive_exp(1'b0, 1'b1, W'($urandom), 1'b1, W'((1 << (k + 1)) - 1));
        for (int k = 0; k < W - 1; k++)
            drive(1'b0, 1'b1, W'($urandom), 1'((k + 1) % 2));
        drive_exp(1'b0, 1'b1, W'($urandom), 1'b0, 8'hAA);

        // Reset pulse between edges in a shift burst
        drive_exp(1'b1, 1'b0, 8'h2D, 1'b0, 8'h2D);
        drive_exp(1'b0, 1'b1, W'($urandom), 1'b0, 8'h5A);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_op", out, 8'h00);
        model = 0;
        #1;
        rst_n = 1'b1;
        drive_exp(1'b0, 1'b1, W'($urandom), 1'b1, 8'h01);

        // Random regression
        for (int n = 0; n < 1000; n++)
            drive(($urandom_range(0, 3) == 0), 1'($urandom), W'($urandom), 1'($urandom));

        // Drain, bounded
        @(negedge clk);
        load  = 1'b0;
        shift = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
